lsu: RTL and testbench

Load/store unit for the RV32I core. Consumes the ALU `result` as the effective address, plus rs2 as store data. Drives a request/grant/response data-memory bus and returns sign- or zero-extended load data to writeback. It stalls the core through `busy` until the access completes, faults or times out.

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 212 +++++++++++++++++++++
 tb/tb_lsu.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Data-memory request/grant/response bus between the load/store unit and memory.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: decodes/aligns an access, runs it on the memory bus,
// extends load data and aborts with an error when the watchdog expires.
//
//  state | meaning
//  IDLE  | waiting for a memory instruction
//  REQ   | mem_req held with stable address/data until mem_gnt
//  WAIT  | load granted, waiting for mem_rvalid
//  RESP  | one-cycle completion pulse to writeback
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  lsu_if.master       mem
);

  // Counter must hold TIMEOUT itself (a load granted on the last allowed
  // cycle enters WAIT with the count already at the limit).
  localparam int CW  = ($clog2(TIMEOUT + 2) > 8) ? $clog2(TIMEOUT + 2) : 8;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] TMO_LIMIT = CW1'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt;
  logic [CW:0] cnt_inc;
  logic        tmo;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        legal, aligned, accept_ok;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] lane, load_ext;

  logic        busy_d, resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;

  // funct3 legality depends on direction: stores have no unsigned variants
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
  end

  assign aligned = (req_funct3[1:0] == 2'b00) ||
                   (req_funct3[1:0] == 2'b01 && !req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
  assign accept_ok = legal && aligned;

  // Replicate store data into every lane and enable only the addressed bytes
  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign lane = mem.mem_rdata >> {off_q, 3'b000};

  // Sign or zero extend the selected lane of the returned word
  always_comb begin
    load_ext = lane;
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: ;
    endcase
  end

  assign cnt_inc = {1'b0, cnt} + CW1'(1);
  assign tmo     = TMO_EN && (cnt_inc >= TMO_LIMIT);

  // State register plus the access context and watchdog it needs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      off_q <= 2'b00;
      f3_q  <= 3'b000;
    end else begin
      state <= state_d;
      if (state == IDLE && state_d == REQ) begin
        cnt   <= '0;
        off_q <= req_addr[1:0];
        f3_q  <= req_funct3;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt_inc[CW-1:0];
      end
    end
  end

  // Next state; a grant or data beat on the watchdog's last cycle still wins
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_valid) state_d = accept_ok ? REQ : RESP;
      REQ: begin
        if (mem.mem_gnt)  state_d = mem.mem_we ? RESP : WAIT;
        else if (tmo)     state_d = RESP;
      end
      WAIT: begin
        if (mem.mem_rvalid || tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next value of every registered output, keyed on the transition being taken
  always_comb begin
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
    mem_req_d    = (state_d == REQ);
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    mem_we_d     = mem.mem_we;
    mem_addr_d   = mem.mem_addr;
    mem_wstrb_d  = mem.mem_wstrb;
    mem_wdata_d  = mem.mem_wdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          resp_rdata_d = 32'h0;
          if (accept_ok) begin
            resp_err_d  = 1'b0;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = req_we ? st_wstrb : 4'b0000;
            mem_wdata_d = req_we ? st_wdata : 32'h0;
          end else begin
            resp_err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (state_d != REQ) begin
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'h0;
          mem_wstrb_d  = 4'b0000;
          mem_wdata_d  = 32'h0;
          resp_err_d   = !mem.mem_gnt;
          resp_rdata_d = 32'h0;
        end
      end
      WAIT: begin
        if (state_d == RESP) begin
          resp_err_d   = !mem.mem_rvalid;
          resp_rdata_d = mem.mem_rvalid ? load_ext : 32'h0;
        end
      end
      default: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
    endcase
  end

  // Output registers; reset clears everything, including an in-flight mem_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'h0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= 32'h0;
    end else begin
      busy          <= busy_d;
      resp_valid    <= resp_valid_d;
      resp_err      <= resp_err_d;
      resp_rdata    <= resp_rdata_d;
      mem.mem_req   <= mem_req_d;
      mem.mem_we    <= mem_we_d;
      mem.mem_addr  <= mem_addr_d;
      mem.mem_wstrb <= mem_wstrb_d;
      mem.mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and randomized accesses checked against a
// behavioural access model, plus watchdog and asynchronous reset scenarios.
module tb_lsu;
  localparam int unsigned T_MAIN = 8;
  localparam int unsigned T_WD   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        w_req_valid, w_req_we;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr, w_req_wdata;
  logic        w_busy, w_resp_valid, w_resp_err;
  logic [31:0] w_resp_rdata;

  lsu_if bus ();
  lsu_if wbus ();

  lsu #(.TIMEOUT(T_MAIN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem(bus)
  );

  lsu #(.TIMEOUT(T_WD)) dut_wd (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_we(w_req_we), .req_funct3(w_req_funct3),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .busy(w_busy), .resp_valid(w_resp_valid), .resp_err(w_resp_err), .resp_rdata(w_resp_rdata),
    .mem(wbus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: which accesses are legal and naturally aligned
  function automatic bit access_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    if (we) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    sz = 1 << f3[1:0];
    return (int'(addr[1:0]) % sz) == 0;
  endfunction

  // Model: value a load returns, by plain arithmetic on the byte offset and width
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int nbits;
    longint v;
    nbits = 8 << f3[1:0];
    v = longint'(word >> (8 * int'(addr[1:0])));
    v = v % (longint'(1) << nbits);
    if (!f3[2] && nbits < 32 && v >= (longint'(1) << (nbits - 1)))
      v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  // One access on the main DUT, with the bench acting as memory. gd = idle
  // REQ cycles before the grant, rd = idle WAIT cycles before rvalid.
  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] word, output logic [31:0] got);
    bit ok;
    int sz, off, lat;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdata;
    ok  = access_ok(we, f3, addr);
    sz  = 1 << f3[1:0];
    off = int'(addr[1:0]);
    e_strb  = 4'b0000;
    e_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      e_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
      if (i >= off && i < off + sz) e_strb[i] = 1'b1;
    end
    if (!ok)     lat = 1;
    else if (we) lat = gd + 2;
    else         lat = gd + rd + 3;
    e_rdata = (ok && !we) ? exp_load(f3, addr, word) : 32'h0;
    got = 32'h0;

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check("busy", {31'b0, busy}, 32'd1);
      check("resp_valid", {31'b0, resp_valid}, (c == lat) ? 32'd1 : 32'd0);
      if (ok && c <= gd + 1) begin
        check("mem_req_hi", {31'b0, bus.mem_req}, 32'd1);
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
        if (we) begin
          check("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, e_strb});
          check("mem_wdata", bus.mem_wdata, e_wdata);
        end
      end else begin
        check("mem_req_lo", {31'b0, bus.mem_req}, 32'd0);
      end
      if (c == lat) begin
        check("resp_err", {31'b0, resp_err}, ok ? 32'd0 : 32'd1);
        check("resp_rdata", resp_rdata, e_rdata);
        got = resp_rdata;
        req_valid = 1'b0;
      end else begin
        // the core may present anything while stalled; it must be ignored
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
      bus.mem_rdata = $urandom;
      if (ok && c < gd + 1) bus.mem_gnt = 1'b0;
      else if (ok && c == gd + 1) bus.mem_gnt = 1'b1;
      else bus.mem_gnt = 1'($urandom);
      if (ok && !we && c >= gd + 2 && c <= gd + rd + 2) begin
        bus.mem_rvalid = (c == gd + rd + 2);
        if (c == gd + rd + 2) bus.mem_rdata = word;
      end else begin
        bus.mem_rvalid = 1'($urandom);
      end
    end
    @(negedge clk);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    check("mem_req_after", {31'b0, bus.mem_req}, 32'd0);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
  endtask

  // Watchdog on the TIMEOUT=4 instance; gnt_at = REQ cycle granted, 0 = never
  task automatic wd_access(input logic we, input int gnt_at);
    w_req_valid = 1'b1; w_req_we = we; w_req_funct3 = 3'b010;
    w_req_addr = 32'h40; w_req_wdata = 32'h1234_5678;
    wbus.mem_gnt = 1'b0; wbus.mem_rvalid = 1'b0; wbus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    for (int c = 1; c <= int'(T_WD) + 1; c++) begin
      @(negedge clk);
      check("wd_busy", {31'b0, w_busy}, 32'd1);
      check("wd_resp_valid", {31'b0, w_resp_valid}, (c == int'(T_WD) + 1) ? 32'd1 : 32'd0);
      check("wd_mem_req", {31'b0, wbus.mem_req},
            ((gnt_at == 0 && c <= int'(T_WD)) || c <= gnt_at) ? 32'd1 : 32'd0);
      if (c == int'(T_WD) + 1) begin
        check("wd_resp_err", {31'b0, w_resp_err}, 32'd1);
        check("wd_resp_rdata", w_resp_rdata, 32'h0);
        w_req_valid = 1'b0;
      end
      wbus.mem_gnt = (c == gnt_at);
    end
    @(negedge clk);
    check("wd_busy_after", {31'b0, w_busy}, 32'd0);
    wbus.mem_gnt = 1'b0;
  endtask

  // Start a load on the main DUT and stop at the negedge of REQ cycle 1
  task automatic start_load(input logic [31:0] addr, input logic [2:0] f3);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    check({tag, "_mem_wstrb"}, {28'b0, bus.mem_wstrb}, 32'h0);
  endtask

  // Pulse rst mid-cycle, check the asynchronous clear, release on the next negedge
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_all_zero(tag);
    req_valid = 1'b0;
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    w_req_valid = 1'b0; w_req_we = 1'b0; w_req_funct3 = 3'b0; w_req_addr = 32'h0; w_req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    wbus.mem_gnt = 1'b0; wbus.mem_rvalid = 1'b0; wbus.mem_rdata = 32'h0;
    #1 check_all_zero("reset");
    check("reset_wd_busy", {31'b0, w_busy}, 32'd0);
    check("reset_wd_mem_req", {31'b0, wbus.mem_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // stray grant/data pulses while idle are ignored
    for (int i = 0; i < 4; i++) begin
      bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
      @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_resp", {31'b0, resp_valid}, 32'd0);
      check("idle_mem_req", {31'b0, bus.mem_req}, 32'd0);
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;

    // stores
    do_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, r);
    do_access(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 32'h0, r);
    do_access(1'b1, 3'b001, 32'h202, 32'h0000_1234, 1, 0, 32'h0, r);

    // load extension against fixed expected values
    do_access(1'b0, 3'b000, 32'h301, 32'h0, 0, 0, 32'h80F0_7F81, r);
    check("lb_301", r, 32'h0000_007F);
    do_access(1'b0, 3'b100, 32'h300, 32'h0, 0, 0, 32'h80F0_7F81, r);
    check("lbu_300", r, 32'h0000_0081);
    do_access(1'b0, 3'b000, 32'h300, 32'h0, 0, 1, 32'h80F0_7F81, r);
    check("lb_300", r, 32'hFFFF_FF81);
    do_access(1'b0, 3'b001, 32'h302, 32'h0, 1, 0, 32'h80F0_7F81, r);
    check("lh_302", r, 32'hFFFF_80F0);
    do_access(1'b0, 3'b101, 32'h302, 32'h0, 0, 0, 32'h80F0_7F81, r);
    check("lhu_302", r, 32'h0000_80F0);
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h80F0_7F81, r);
    check("lw_300", r, 32'h80F0_7F81);

    // error path
    do_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, r);
    do_access(1'b1, 3'b001, 32'h001, 32'h5555_5555, 0, 0, 32'h0, r);
    do_access(1'b0, 3'b011, 32'h000, 32'h0, 0, 0, 32'hFFFF_FFFF, r);
    check("err_rdata", r, 32'h0);

    // long grant and data latency with noise on the ignored inputs
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 3, 2, 32'h1357_9BDF, r);
    check("lw_slow", r, 32'h1357_9BDF);

    // watchdog at TIMEOUT=4: store never granted, load granted but no data
    wd_access(1'b1, 0);
    wd_access(1'b0, 1);

    // reset while requesting: mem_req drops at once
    start_load(32'h300, 3'b010);
    check("rst_req_pre", {31'b0, bus.mem_req}, 32'd1);
    mid_reset("rst_req");

    // reset while waiting for data; a late rvalid must be ignored
    start_load(32'h300, 3'b010);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("rst_wait_pre", {31'b0, busy}, 32'd1);
    mid_reset("rst_wait");
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      check("late_rvalid_resp", {31'b0, resp_valid}, 32'd0);
      check("late_rvalid_busy", {31'b0, busy}, 32'd0);
    end

    // reset during the completion pulse
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102;
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_pre", {31'b0, resp_valid}, 32'd1);
    mid_reset("rst_resp");

    // the unit works normally after reset
    do_access(1'b0, 3'b001, 32'h302, 32'h0, 0, 0, 32'h80F0_7F81, r);
    check("post_reset_lh", r, 32'hFFFF_80F0);

    // randomized mix of legal, illegal and misaligned accesses
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      do_access(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
